// File: rtl/apb_master_fsm.sv
// apb_master_fsm
//   Downstream stage of the AXI4-Lite slave bridge. It runs one APB4 transaction
//   (SETUP then ACCESS) for each request the bridge presents. It reports completion
//   with a one-cycle apb_done pulse together with err_flag and apb_rdata.
//
// Ports
//   ACLK, ARESET          clock; synchronous active-high reset
//   transfer/read/write   bridge request; read and write are held until apb_done
//   PSTRB_in, apb_waddr,  write strobes, write address, read address, write data
//   apb_raddr, apb_wdata
//   apb_rdata, apb_done,  read data, completion pulse and error status to the bridge
//   err_flag
//   PSEL, PENABLE, PWRITE,
//   PADDR, PWDATA, PSTRB  APB4 master outputs
//   PREADY, PRDATA,
//   PSLVERR               APB4 slave responses
//
// Configuration
//   APB_TIMEOUT_EN   When defined, an ACCESS phase that sees TIMEOUT_CYCLES cycles of
//                    PREADY=0 is aborted. The abort reports apb_done with err_flag=1.
//                    When undefined, ACCESS waits for PREADY indefinitely.
module apb_master_fsm #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic                    transfer,
  input  logic                    read,
  input  logic                    write,
  input  logic [DATA_WIDTH/8-1:0] PSTRB_in,
  input  logic [ADDR_WIDTH-1:0]   apb_waddr,
  input  logic [ADDR_WIDTH-1:0]   apb_raddr,
  input  logic [DATA_WIDTH-1:0]   apb_wdata,
  output logic [DATA_WIDTH-1:0]   apb_rdata,
  output logic                    apb_done,
  output logic                    err_flag,
  output logic                    PSEL,
  output logic                    PENABLE,
  output logic                    PWRITE,
  output logic [ADDR_WIDTH-1:0]   PADDR,
  output logic [DATA_WIDTH-1:0]   PWDATA,
  output logic [DATA_WIDTH/8-1:0] PSTRB,
  input  logic                    PREADY,
  input  logic [DATA_WIDTH-1:0]   PRDATA,
  input  logic                    PSLVERR
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

  state_e                  state_q, state_d;
  logic                    pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
  logic [DATA_WIDTH/8-1:0] pstrb_q, pstrb_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;

  // A zero-cycle timeout has no meaning; reject it when the design is elaborated.
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("apb_master_fsm: TIMEOUT_CYCLES must be at least 1");
  end

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
`endif

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q  <= IDLE;
      pwrite_q <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      pstrb_q  <= '0;
      rdata_q  <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
`ifdef APB_TIMEOUT_EN
      wait_cnt_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      pwrite_q <= pwrite_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      pstrb_q  <= pstrb_d;
      rdata_q  <= rdata_d;
      done_q   <= done_d;
      err_q    <= err_d;
`ifdef APB_TIMEOUT_EN
      wait_cnt_q <= wait_cnt_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    pwrite_d = pwrite_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    pstrb_d  = pstrb_q;
    rdata_d  = rdata_q;
    done_d   = 1'b0;
    err_d    = err_q;
`ifdef APB_TIMEOUT_EN
    wait_cnt_d = wait_cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        // The bridge drops read/write only after it sees apb_done. Accepting in the
        // done cycle would therefore replay the request that just finished.
        if (transfer && (read || write) && !done_q) begin
          state_d  = SETUP;
          // A write takes priority. A simultaneous read stays pending for the next slot.
          pwrite_d = write;
          paddr_d  = write ? apb_waddr : apb_raddr;
          pwdata_d = apb_wdata;
          pstrb_d  = write ? PSTRB_in : '0;
`ifdef APB_TIMEOUT_EN
          wait_cnt_d = '0;
`endif
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (PREADY) begin
          state_d = IDLE;
          done_d  = 1'b1;
          err_d   = PSLVERR;
          if (!pwrite_q) rdata_d = PRDATA;
        end
`ifdef APB_TIMEOUT_EN
        // This is the wait cycle that brings the count up to TIMEOUT_CYCLES.
        // PREADY on the same edge still wins through the branch above.
        else if (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  assign PSEL      = (state_q != IDLE);
  assign PENABLE   = (state_q == ACCESS);
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign PSTRB     = pstrb_q;
  assign apb_rdata = rdata_q;
  assign apb_done  = done_q;
  assign err_flag  = err_q;

endmodule

// File: tb/tb_apb_master_fsm.sv
module tb_apb_master_fsm;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int SW  = DW / 8;
  localparam int TMO = 16;

  logic          ACLK = 1'b0;
  logic          ARESET = 1'b1;
  logic          transfer = 1'b0, read = 1'b0, write = 1'b0;
  logic [SW-1:0] PSTRB_in = '0;
  logic [AW-1:0] apb_waddr = '0, apb_raddr = '0;
  logic [DW-1:0] apb_wdata = '0;
  logic [DW-1:0] apb_rdata;
  logic          apb_done, err_flag, PSEL, PENABLE, PWRITE;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA;
  logic [SW-1:0] PSTRB;
  logic          PREADY = 1'b0;
  logic [DW-1:0] PRDATA = '0;
  logic          PSLVERR = 1'b0;

  apb_master_fsm #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .transfer(transfer), .read(read), .write(write),
    .PSTRB_in(PSTRB_in), .apb_waddr(apb_waddr), .apb_raddr(apb_raddr),
    .apb_wdata(apb_wdata), .apb_rdata(apb_rdata), .apb_done(apb_done),
    .err_flag(err_flag), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB), .PREADY(PREADY),
    .PRDATA(PRDATA), .PSLVERR(PSLVERR)
  );

  // One expected APB transaction, as the bridge would see it.
  typedef struct {
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] strb;
    logic [DW-1:0] rdata;
    bit            err;
    int            req_cyc;
    int            lat;
  } exp_t;

  exp_t          exp_q[$];
  int            checks = 0, failures = 0;
  int            cyc = 0, last_done = -10, sel_n = 0;
  bit            mon_off = 1'b1;
  logic [DW-1:0] model_rdata = '0;

  always #5 ACLK = ~ACLK;
  always @(posedge ACLK) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d required < 20000", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Inputs change 1 time unit after the rising edge.
  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  // Monitor: samples on the falling edge and checks against the scoreboard head.
  always @(negedge ACLK) begin
    if (mon_off || ARESET) begin
      sel_n = 0;
    end else begin
      if (PSEL) begin
        if (exp_q.size() == 0) begin
          chk("psel_without_request", 1, 0);
        end else begin
          chk("pwrite", PWRITE, exp_q[0].wr);
          chk("paddr", PADDR, exp_q[0].addr);
          chk("pwdata", PWDATA, exp_q[0].wdata);
          chk("pstrb", PSTRB, exp_q[0].strb);
          chk("penable_phase", PENABLE, (sel_n != 0));
        end
        sel_n++;
      end else begin
        sel_n = 0;
      end
      if (apb_done) begin
        if (exp_q.size() == 0) begin
          chk("done_without_request", 1, 0);
        end else begin
          exp_t e;
          int start;
          e = exp_q.pop_front();
          // A request held through the previous done cycle is accepted one edge later.
          start = (e.req_cyc > last_done + 1) ? e.req_cyc : last_done + 1;
          chk("done_rdata", apb_rdata, e.rdata);
          chk("done_err", err_flag, e.err);
          chk("done_latency", cyc - start, e.lat);
          chk("done_psel_low", {PSEL, PENABLE}, 2'b00);
        end
        last_done = cyc;
      end
    end
  end

  // Slave side of one transaction: wait for ACCESS, insert wait states, then respond.
  task automatic slave_phase(input int waits, input bit err, input logic [DW-1:0] pd,
                             input bit scramble);
    int n = 0;
    while (!(PSEL && PENABLE)) begin
      step();
      n++;
      if (n > 20) begin
        chk("access_reached", 0, 1);
        return;
      end
    end
    repeat (waits) begin
      if (scramble) begin
        apb_waddr = $urandom; apb_wdata = $urandom; PSTRB_in = SW'($urandom);
        apb_raddr = $urandom;
      end
      step();
    end
    PREADY = 1'b1; PRDATA = pd; PSLVERR = err;
    step();
    PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = $urandom;
  endtask

  task automatic issue(input bit rd, input bit wr, input logic [AW-1:0] waddr,
                       input logic [AW-1:0] raddr, input logic [DW-1:0] wdata,
                       input logic [SW-1:0] strb, input int wait_a, input bit err_a,
                       input int wait_b, input bit err_b, input logic [DW-1:0] pd);
    exp_t e;
    apb_waddr = waddr; apb_raddr = raddr; apb_wdata = wdata; PSTRB_in = strb;
    if (wr) begin
      e.wr = 1'b1; e.addr = waddr; e.wdata = wdata; e.strb = strb;
      e.rdata = model_rdata; e.err = err_a; e.req_cyc = cyc; e.lat = 3 + wait_a;
      exp_q.push_back(e);
    end
    if (rd) begin
      model_rdata = pd;
      e.wr = 1'b0; e.addr = raddr; e.wdata = wdata; e.strb = '0;
      e.rdata = pd; e.err = wr ? err_b : err_a; e.req_cyc = cyc;
      e.lat = 3 + (wr ? wait_b : wait_a);
      exp_q.push_back(e);
    end
    transfer = 1'b1; read = rd; write = wr;
    if (rd && wr) begin
      slave_phase(wait_a, err_a, $urandom, 1'b0);
      write = 1'b0;
      slave_phase(wait_b, err_b, pd, 1'b1);
    end else begin
      slave_phase(wait_a, err_a, pd, 1'b1);
    end
    transfer = 1'b0; read = 1'b0; write = 1'b0;
  endtask

  initial begin
    int n;
    int dones;
    // Reset state
    repeat (2) step();
    chk("rst_apb_rdata", apb_rdata, 0);
    chk("rst_apb_done", apb_done, 0);
    chk("rst_err_flag", err_flag, 0);
    chk("rst_psel", PSEL, 0);
    chk("rst_penable", PENABLE, 0);
    chk("rst_pwrite", PWRITE, 0);
    chk("rst_paddr", PADDR, 0);
    chk("rst_pwdata", PWDATA, 0);
    chk("rst_pstrb", PSTRB, 0);
    ARESET = 1'b0;
    mon_off = 1'b0;
    step();

    // Directed cases
    issue(0, 1, 32'h1000, 32'h0, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 32'h0);
    step();
    issue(1, 0, 32'h0, 32'h2004, 32'h1234_5678, 4'hA, 3, 0, 0, 0, 32'hCAFEF00D);
    step();
    issue(0, 1, 32'h3000, 32'h0, 32'h0BAD_0BAD, 4'h3, 1, 1, 0, 0, 32'h0);
    issue(1, 0, 32'h0, 32'h3000, 32'h0, 4'hF, 0, 0, 0, 0, 32'h5555_AAAA);
    step();
    issue(1, 1, 32'h4000, 32'h4008, 32'h1111_2222, 4'hC, 0, 0, 1, 0, 32'h9999_8888);
    step();

    // Reset while in ACCESS: no done, everything cleared
    mon_off = 1'b1;
    apb_waddr = 32'h5000; apb_wdata = 32'h7777_7777; PSTRB_in = 4'hF;
    transfer = 1'b1; write = 1'b1;
    n = 0;
    while (!(PSEL && PENABLE) && n < 20) begin step(); n++; end
    chk("mid_rst_reached_access", {PSEL, PENABLE}, 2'b11);
    ARESET = 1'b1;
    step();
    chk("mid_rst_psel", PSEL, 0);
    chk("mid_rst_penable", PENABLE, 0);
    chk("mid_rst_done", apb_done, 0);
    chk("mid_rst_paddr", PADDR, 0);
    chk("mid_rst_rdata", apb_rdata, 0);
    ARESET = 1'b0; transfer = 1'b0; write = 1'b0;
    step();
    chk("post_rst_done", apb_done, 0);
    model_rdata = '0;
    exp_q.delete();
    mon_off = 1'b0;
    issue(0, 1, 32'h6000, 32'h0, 32'hFEED_FACE, 4'h5, 2, 0, 0, 0, 32'h0);

    // Randomized traffic, with idle gaps that sometimes raise transfer alone
    for (int t = 0; t < 40; t++) begin
      int kind;
      kind = $urandom_range(0, 2);
      repeat ($urandom_range(0, 2)) begin
        transfer = 1'($urandom_range(0, 1));
        step();
      end
      transfer = 1'b0;
      issue(kind != 0, kind != 1, $urandom, $urandom, $urandom, SW'($urandom),
            $urandom_range(0, 4), ($urandom_range(0, 3) == 0),
            $urandom_range(0, 4), ($urandom_range(0, 3) == 0), $urandom);
    end
    step();

    // PREADY stuck low
`ifdef APB_TIMEOUT_EN
    begin
      exp_t e;
      apb_raddr = 32'h7000;
      e.wr = 1'b0; e.addr = 32'h7000; e.wdata = apb_wdata; e.strb = '0;
      e.rdata = model_rdata; e.err = 1'b1; e.req_cyc = cyc; e.lat = 3 + TMO - 1;
      exp_q.push_back(e);
      transfer = 1'b1; read = 1'b1;
      n = 0;
      while (!apb_done && n < 60) begin step(); n++; end
      chk("timeout_done_seen", apb_done, 1);
      transfer = 1'b0; read = 1'b0;
      step();
    end
`else
    mon_off = 1'b1;
    apb_raddr = 32'h7000;
    transfer = 1'b1; read = 1'b1;
    dones = 0;
    repeat (100) begin
      step();
      if (apb_done) dones++;
    end
    chk("no_done_without_timeout", dones, 0);
    chk("still_in_access", {PSEL, PENABLE}, 2'b11);
    ARESET = 1'b1;
    step();
    ARESET = 1'b0; transfer = 1'b0; read = 1'b0;
    step();
`endif

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
